// File: rtl/div_pkg.sv
// Shared types for the iterative divider: FSM state and exception codes.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'd0,
    EXC_OVERFLOW    = 2'd1,
    EXC_DIV_BY_ZERO = 2'd2
  } div_exc_t;

endpackage

// File: rtl/iterative_divider_if.sv
// Handshake/operand/result bundle for iterative_divider.
// Sticky flag signals exist only when DIV_STICKY_FLAGS_EN is defined.
interface iterative_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;
`ifdef DIV_STICKY_FLAGS_EN
  logic             flag_clr;
  logic             sticky_overflow;
  logic             sticky_div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor, flag_clr,
    input  ready, valid, quotient, remainder, overflow, div_by_zero,
           sticky_overflow, sticky_div_by_zero
  );
  modport slave (
    input  start, signed_mode, dividend, divisor, flag_clr,
    output ready, valid, quotient, remainder, overflow, div_by_zero,
           sticky_overflow, sticky_div_by_zero
  );
`else
  modport master (
    output start, signed_mode, dividend, divisor,
    input  ready, valid, quotient, remainder, overflow, div_by_zero
  );
  modport slave (
    input  start, signed_mode, dividend, divisor,
    output ready, valid, quotient, remainder, overflow, div_by_zero
  );
`endif
endinterface

// File: rtl/div_exception_detect.sv
// Combinational classification of an operand pair: divide-by-zero,
// signed overflow (most-negative / -1) or none.
module div_exception_detect
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output div_exc_t         exc
);

  // Classify operands; zero divisor takes precedence in both modes
  always_comb begin
    exc = EXC_NONE;
    if (divisor == {WIDTH{1'b0}}) begin
      exc = EXC_DIV_BY_ZERO;
    end else if (signed_mode &&
                 (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (divisor == {WIDTH{1'b1}})) begin
      exc = EXC_OVERFLOW;
    end else begin
      exc = EXC_NONE;
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned.
// Optional sticky exception flags under DIV_STICKY_FLAGS_EN.
module iterative_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  iterative_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_r, state_nx_s;
  div_exc_t         exc_s;
  logic             accept_s, last_iter_s;
  logic [WIDTH:0]   shifted_s, trial_s;
  logic [WIDTH-1:0] rem_r, rem_nx_s, quo_r, quo_nx_s, div_r;
  logic [WIDTH-1:0] mag_a_s, mag_b_s, fin_q_s, fin_r_s, exc_q_s, exc_r_s;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r, neg_r_r, neg_a_s, neg_b_s;
  logic [WIDTH-1:0] res_q_r, res_r_r;
  logic             res_ovf_r, res_dbz_r, fire_r;

  div_exception_detect #(.WIDTH(WIDTH)) u_exc (
    .dividend    (bus.dividend),
    .divisor     (bus.divisor),
    .signed_mode (bus.signed_mode),
    .exc         (exc_s)
  );

  assign accept_s    = bus.start && (state_r != ST_CALC);
  assign last_iter_s = (state_r == ST_CALC) && (cnt_r == CW'(WIDTH - 1));
  assign neg_a_s     = bus.signed_mode && bus.dividend[WIDTH-1];
  assign neg_b_s     = bus.signed_mode && bus.divisor[WIDTH-1];
  // Unsigned negation of -2^(WIDTH-1) yields exactly 2^(WIDTH-1) as a magnitude
  assign mag_a_s     = neg_a_s ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
  assign mag_b_s     = neg_b_s ? ({WIDTH{1'b0}} - bus.divisor) : bus.divisor;

  // One restoring step on the WIDTH+1-bit partial remainder
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, div_r};
    if (!trial_s[WIDTH]) begin
      rem_nx_s = trial_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = shifted_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end
    fin_q_s = neg_q_r ? ({WIDTH{1'b0}} - quo_nx_s) : quo_nx_s;
    fin_r_s = neg_r_r ? ({WIDTH{1'b0}} - rem_nx_s) : rem_nx_s;
  end

  // Fixed results for exceptional operand pairs
  always_comb begin
    case (exc_s)
      EXC_DIV_BY_ZERO: begin
        exc_q_s = {WIDTH{1'b1}};
        exc_r_s = bus.dividend;
      end
      EXC_OVERFLOW: begin
        exc_q_s = bus.dividend;
        exc_r_s = {WIDTH{1'b0}};
      end
      default: begin
        exc_q_s = {WIDTH{1'b0}};
        exc_r_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nx_s = (exc_s == EXC_NONE) ? ST_CALC : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_iter_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and staging of the finished result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      div_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      res_q_r   <= {WIDTH{1'b0}};
      res_r_r   <= {WIDTH{1'b0}};
      res_ovf_r <= 1'b0;
      res_dbz_r <= 1'b0;
      fire_r    <= 1'b0;
    end else if (accept_s) begin
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= mag_a_s;
      div_r   <= mag_b_s;
      cnt_r   <= {CW{1'b0}};
      neg_q_r <= neg_a_s ^ neg_b_s;
      neg_r_r <= neg_a_s;
      if (exc_s != EXC_NONE) begin
        res_q_r   <= exc_q_s;
        res_r_r   <= exc_r_s;
        res_ovf_r <= (exc_s == EXC_OVERFLOW);
        res_dbz_r <= (exc_s == EXC_DIV_BY_ZERO);
        fire_r    <= 1'b1;
      end else begin
        fire_r    <= 1'b0;
      end
    end else if (state_r == ST_CALC) begin
      rem_r <= rem_nx_s;
      quo_r <= quo_nx_s;
      cnt_r <= cnt_r + CW'(1);
      if (last_iter_s) begin
        res_q_r   <= fin_q_s;
        res_r_r   <= fin_r_s;
        res_ovf_r <= 1'b0;
        res_dbz_r <= 1'b0;
        fire_r    <= 1'b1;
      end else begin
        fire_r    <= 1'b0;
      end
    end else begin
      fire_r <= 1'b0;
    end
  end

  // Registered outputs; results only move together with a valid pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ready       <= 1'b1;
      bus.valid       <= 1'b0;
      bus.quotient    <= {WIDTH{1'b0}};
      bus.remainder   <= {WIDTH{1'b0}};
      bus.overflow    <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.ready <= (state_nx_s != ST_CALC);
      bus.valid <= fire_r;
      if (fire_r) begin
        bus.quotient    <= res_q_r;
        bus.remainder   <= res_r_r;
        bus.overflow    <= res_ovf_r;
        bus.div_by_zero <= res_dbz_r;
      end else begin
        bus.quotient    <= bus.quotient;
        bus.remainder   <= bus.remainder;
        bus.overflow    <= bus.overflow;
        bus.div_by_zero <= bus.div_by_zero;
      end
    end
  end

`ifdef DIV_STICKY_FLAGS_EN
  // Sticky flags: a result carrying the flag wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sticky_overflow    <= 1'b0;
      bus.sticky_div_by_zero <= 1'b0;
    end else begin
      bus.sticky_overflow    <= (bus.sticky_overflow & ~bus.flag_clr) |
                                (fire_r & res_ovf_r);
      bus.sticky_div_by_zero <= (bus.sticky_div_by_zero & ~bus.flag_clr) |
                                (fire_r & res_dbz_r);
    end
  end
`endif

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=8): arithmetic reference
// model with cycle-accurate valid timing, directed cases and random traffic.
module tb_iterative_divider;
  import div_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  iterative_divider_if #(.WIDTH(W)) bus();

  iterative_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcount = 0;

  typedef struct {
    int         due;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       ovf;
    logic       dbz;
  } res_t;

  res_t       pend[$];
  logic [W-1:0] m_q = '0, m_r = '0;
  logic       m_ovf = 1'b0, m_dbz = 1'b0, m_valid = 1'b0, m_ready = 1'b1, m_init = 1'b0;
  int         busy_until = 0;
`ifdef DIV_STICKY_FLAGS_EN
  logic       m_sov = 1'b0, m_sdz = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Division defined by plain integer arithmetic (truncation toward zero)
  function automatic res_t model_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    int   sa, sb;
    e.due = 0;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (sm && a == 8'h80 && b == 8'hFF) begin
      e.q = a; e.r = '0; e.ovf = 1'b1;
    end else begin
      sa = sm ? int'($signed(a)) : int'(a);
      sb = sm ? int'($signed(b)) : int'(b);
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end
    return e;
  endfunction

  // Reference model: acceptance, latency and held results
  always @(posedge clk) begin
    res_t e;
    logic set_o, set_z;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      m_q = '0; m_r = '0; m_ovf = 1'b0; m_dbz = 1'b0; m_valid = 1'b0;
      m_ready = 1'b1; busy_until = cyc; m_init = 1'b1;
`ifdef DIV_STICKY_FLAGS_EN
      m_sov = 1'b0; m_sdz = 1'b0;
`endif
    end else begin
      m_valid = 1'b0; set_o = 1'b0; set_z = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        m_q = e.q; m_r = e.r; m_ovf = e.ovf; m_dbz = e.dbz; m_valid = 1'b1;
        set_o = e.ovf; set_z = e.dbz;
      end
`ifdef DIV_STICKY_FLAGS_EN
      m_sov = (m_sov & ~bus.flag_clr) | set_o;
      m_sdz = (m_sdz & ~bus.flag_clr) | set_z;
`endif
      if (bus.start && m_ready) begin
        e = model_div(bus.signed_mode, bus.dividend, bus.divisor);
        if (e.ovf || e.dbz) begin
          e.due = cyc + 1;
          busy_until = cyc;
        end else begin
          e.due = cyc + W + 1;
          busy_until = cyc + W;
        end
        pend.push_back(e);
      end
      m_ready = (cyc >= busy_until);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (bus.valid === 1'b1) vcount++;
    if (m_init) begin
      chk("ready", 32'(bus.ready), 32'(m_ready));
      chk("valid", 32'(bus.valid), 32'(m_valid));
      chk("quotient", 32'(bus.quotient), 32'(m_q));
      chk("remainder", 32'(bus.remainder), 32'(m_r));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
`ifdef DIV_STICKY_FLAGS_EN
      chk("sticky_ovf", 32'(bus.sticky_overflow), 32'(m_sov));
      chk("sticky_dbz", 32'(bus.sticky_div_by_zero), 32'(m_sdz));
`endif
    end
  end

  task automatic op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er,
                    input logic eo, input logic ez, input int elat, input string nm);
    int k;
    int t;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = sm; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (bus.valid !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_lat"}, 32'(cyc - k), 32'(elat));
    chk({nm, "_q"}, 32'(bus.quotient), 32'(eq));
    chk({nm, "_r"}, 32'(bus.remainder), 32'(er));
    chk({nm, "_ovf"}, 32'(bus.overflow), 32'(eo));
    chk({nm, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef DIV_STICKY_FLAGS_EN
    bus.flag_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    rst_n = 1'b1;

    op(1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9, "u100_7");
    op(1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0, 1'b0, 9, "sm7_2");
    op(1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0, 1'b0, 9, "s7_m2");
    op(1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b1, 1'b0, 1, "s_ovf");
    op(1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0, 9, "u80_ff");
    op(1'b0, 8'h05,  8'h00, 8'hFF,  8'h05, 1'b0, 1'b1, 1, "u5_0");
    op(1'b1, 8'h05,  8'h00, 8'hFF,  8'h05, 1'b0, 1'b1, 1, "s5_0");
    op(1'b1, 8'h80,  8'h01, 8'h80,  8'h00, 1'b0, 1'b0, 9, "s_min_1");

`ifdef DIV_STICKY_FLAGS_EN
    repeat (3) @(negedge clk);
    chk("sticky_dbz_held", 32'(bus.sticky_div_by_zero), 32'd1);
    chk("sticky_ovf_held", 32'(bus.sticky_overflow), 32'd1);
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    chk("sticky_dbz_clr", 32'(bus.sticky_div_by_zero), 32'd0);
`endif

    // Reset at CALC cycle 4 aborts the operation without a valid
    @(negedge clk);
    v0 = vcount;
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 8'd200; bus.divisor = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_q", 32'(bus.quotient), 32'd0);
    chk("abort_r", 32'(bus.remainder), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_valid", 32'(vcount - v0), 32'd0);

    // Start held through CALC: ignored there, re-accepted in DONE
    v0 = vcount;
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 8'd100; bus.divisor = 8'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.dividend = 8'($urandom_range(0, 255));
      bus.divisor  = 8'($urandom_range(1, 255));
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_start_valids", 32'(vcount - v0), 32'd2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      bus.start = ($urandom_range(0, 1) == 1);
      bus.signed_mode = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0: bus.divisor = 8'h00;
        1: bus.divisor = 8'hFF;
        default: bus.divisor = 8'($urandom_range(0, 255));
      endcase
      bus.dividend = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
`ifdef DIV_STICKY_FLAGS_EN
      bus.flag_clr = ($urandom_range(0, 15) == 0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
`ifdef DIV_STICKY_FLAGS_EN
    bus.flag_clr = 1'b0;
`endif
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (WIDTH >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; accepted only when ready=1.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have ports dividend, divisor  input  WIDTH each  operands; sampled with start.
REQ-007 SHALL have port ready  output  1  high in IDLE and DONE, low in CALC.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when results update.
REQ-009 SHALL have ports quotient, remainder  output  WIDTH each  results; held stable until the next valid.
REQ-010 SHALL have ports overflow, div_by_zero  output  1 each  exception flags for the current result, held with it.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on accepted start with no exception; IDLE->DONE on accepted start with exception; CALC->DONE after WIDTH iterations; DONE->IDLE, or DONE->CALC/DONE directly on start.
REQ-012 SHALL detect div_by_zero when divisor == 0, in either mode.
REQ-013 SHALL detect overflow only when signed_mode=1, dividend == -2^(WIDTH-1) and divisor == -1.
REQ-014 SHALL, on div_by_zero, produce quotient = all ones and remainder = dividend.
REQ-015 SHALL, on overflow, produce quotient = dividend and remainder = 0.
REQ-016 SHALL, for an exception start accepted at edge k, assert valid after edge k+1 (1-cycle latency), without entering CALC.
REQ-017 SHALL, otherwise, divide magnitudes by radix-2 restoring division, one quotient bit per cycle, WIDTH cycles in CALC; valid after edge k+WIDTH+1.
REQ-018 SHALL, in signed mode, truncate toward zero: quotient negative if operand signs differ; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-019 SHALL use a WIDTH+1-bit partial remainder internally; magnitude of -2^(WIDTH-1) SHALL be formed without loss.
REQ-020 SHALL ignore start while in CALC; operands and results SHALL be unaffected.
REQ-021 SHALL assert valid for exactly one cycle per accepted start and never without one.

Reset
REQ-022 SHALL, with rst_n=0 at a rising edge, enter IDLE and clear quotient, remainder, overflow, div_by_zero and valid to 0, and set ready to 1, including mid-CALC.
REQ-023 SHALL produce no valid for an operation aborted by reset.

Configuration
REQ-024 SHALL support macro DIV_STICKY_FLAGS_EN.
REQ-025 With DIV_STICKY_FLAGS_EN defined: add input flag_clr (1) and outputs sticky_overflow, sticky_div_by_zero (1 each), set on any valid with the matching flag and cleared by flag_clr or reset; set wins over simultaneous flag_clr.
REQ-026 Without DIV_STICKY_FLAGS_EN: those ports and their registers SHALL not exist; other behaviour is identical.

Structure
REQ-027 SHALL take the state enum type (div_state_t) and an exception-code typedef (none/overflow/div_by_zero) from shared package div_pkg.
REQ-028 SHALL place exception detection (REQ-012/013) in combinational sub-module div_exception_detect, parametrised by WIDTH, with inputs dividend, divisor and signed_mode.

Verification (WIDTH=8)
REQ-029 Unsigned 100/7, start at edge 0 -> valid after edge 9; q=14, r=2; flags 0.
REQ-030 Signed -7/2 -> q=-3 (0xFD), r=-1 (0xFF); signed 7/-2 -> q=-3, r=1.
REQ-031 Signed 0x80/0xFF -> overflow=1, q=0x80, r=0, valid after 1 cycle; the same operands unsigned -> q=0, r=0x80, overflow=0.
REQ-032 5/0 in both modes -> div_by_zero=1, q=0xFF, r=5, valid after 1 cycle; with DIV_STICKY_FLAGS_EN, sticky_div_by_zero stays 1 until flag_clr.
REQ-033 Reset asserted at CALC cycle 4 -> IDLE next cycle, outputs 0, no valid; start held during CALC is ignored; back-to-back start in DONE is accepted.
